data_cache_controller: RTL and testbench

DATA_CACHE_CONTROLLER -- requirements
Module: data_cache_controller

---
 rtl/data_cache_controller.sv | 156 +++++++++++++++
 tb/tb_data_cache_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache_controller.sv
// data_cache_controller
//   Direct-mapped, write-through, no-write-allocate data cache controller.
//   Geometry: 32 lines x 4 words x 32 bits. Word address layout is
//   tag[9:7], index[6:2], offset[1:0].
//
// Ports
//   clk        : single clock, rising-edge active
//   rst        : synchronous, active-low reset
//   cpu_rd     : CPU load request, held until stall is low
//   cpu_wr     : CPU store request, held until stall is low (wins over cpu_rd)
//   cpu_addr   : CPU word address
//   cpu_wdata  : CPU store data
//   cpu_rdata  : load data, valid when cpu_rd=1 and stall=0, otherwise 0
//   stall      : CPU must hold its request and inputs while high
//   mem_rd_en  : block read enable to data memory
//   mem_wr_en  : word write enable to data memory
//   mem_addr   : latched request address
//   mem_wdata  : latched store data
//   mem_rdata  : 128-bit block from memory, word n at bits [32n+31:32n]
//   mem_done   : one-cycle registered completion pulse from memory
module data_cache_controller (
    input  logic         clk,
    input  logic         rst,
    input  logic         cpu_rd,
    input  logic         cpu_wr,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         stall,
    output logic         mem_rd_en,
    output logic         mem_wr_en,
    output logic [9:0]   mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [31:0]  valid;
    logic [2:0]   tag_mem  [32];
    logic [127:0] data_mem [32];

    logic [9:0]   addr_q;
    logic [31:0]  wdata_q;

    logic [2:0]   req_tag;
    logic [4:0]   req_idx;
    logic [1:0]   req_off;
    logic [4:0]   lat_idx;
    logic [1:0]   lat_off;
    logic         hit;

    function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] off);
        return blk[{off, 5'b0} +: 32];
    endfunction

    assign req_tag = cpu_addr[9:7];
    assign req_idx = cpu_addr[6:2];
    assign req_off = cpu_addr[1:0];
    assign lat_idx = addr_q[6:2];
    assign lat_off = addr_q[1:0];
    assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // The memory transfer starts in the same cycle the request is accepted,
    // so the enable is raised from IDLE as well; the memory only samples the
    // address/data once its transfer completes, by which time the latches hold them.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        cpu_rdata  = '0;
        case (state)
            IDLE: begin
                if (cpu_wr) begin
                    stall      = 1'b1;
                    mem_wr_en  = 1'b1;
                    state_next = WR_MEM;
                end else if (cpu_rd) begin
                    if (hit) begin
                        cpu_rdata = word_sel(data_mem[req_idx], req_off);
                    end else begin
                        stall      = 1'b1;
                        mem_rd_en  = 1'b1;
                        state_next = RD_MISS;
                    end
                end
            end
            RD_MISS: begin
                if (mem_done) begin
                    cpu_rdata  = word_sel(mem_rdata, lat_off);
                    state_next = IDLE;
                end else begin
                    stall     = 1'b1;
                    mem_rd_en = 1'b1;
                end
            end
            WR_MEM: begin
                if (mem_done) begin
                    state_next = IDLE;
                end else begin
                    stall     = 1'b1;
                    mem_wr_en = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            valid   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (cpu_wr) begin
                    addr_q  <= cpu_addr;
                    wdata_q <= cpu_wdata;
                end else if (cpu_rd && !hit) begin
                    addr_q <= cpu_addr;
                end
            end
            if (state == RD_MISS && mem_done) begin
                valid[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays are not cleared; the valid bits alone qualify them.
    // A reset cycle suppresses both the store-hit update and the miss fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == IDLE && cpu_wr && hit) begin
                data_mem[req_idx][{req_off, 5'b0} +: 32] <= cpu_wdata;
            end
            if (state == RD_MISS && mem_done) begin
                tag_mem[lat_idx]  <= addr_q[9:7];
                data_mem[lat_idx] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller
//   Directed bench for data_cache_controller with a behavioural data memory
//   (4 enabled cycles then a registered one-cycle mem_done) and a load
//   scoreboard queue.
module tb_data_cache_controller;

    logic         clk;
    logic         rst;
    logic         cpu_rd;
    logic         cpu_wr;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         mem_rd_en;
    logic         mem_wr_en;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_done;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] sb [$];
    logic [31:0] ref_mem [1024];

    logic [31:0] mem [1024];
    logic [1:0]  cnt;
    logic        mem_init;

    data_cache_controller dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: contents loaded once, counter and done
    // pulse cleared by every reset.
    always @(posedge clk) begin
        if (!rst) begin
            cnt      <= 2'd0;
            mem_done <= 1'b0;
            if (mem_init !== 1'b1) begin
                for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
                mem_init <= 1'b1;
            end
        end else begin
            mem_done <= 1'b0;
            if (mem_rd_en || mem_wr_en) begin
                if (cnt == 2'd3) begin
                    mem_done <= 1'b1;
                    cnt      <= 2'd0;
                    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    assign mem_rdata = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                        mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [9:0] addr, input int nstall);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;
        cpu_addr = addr;
        sb.push_back(ref_mem[addr]);
        while (n < 12 && !done) begin
            @(negedge clk);
            chk("ld_rd_en", 32'(mem_rd_en), 32'(n < nstall));
            chk("ld_wr_en", 32'(mem_wr_en), 32'd0);
            if (!stall) begin
                chk("ld_rdata", cpu_rdata, sb.pop_front());
                chk("ld_latency", 32'(n), 32'(nstall));
                done = 1'b1;
            end else begin
                chk("ld_stall_rdata", cpu_rdata, 32'd0);
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            chk("ld_timeout", 32'(done), 32'd1);
            void'(sb.pop_front());
        end
        cpu_rd = 1'b0;
    endtask

    task automatic do_store(input logic [9:0] addr, input logic [31:0] data, input logic both);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        cpu_wr    = 1'b1;
        cpu_rd    = both;
        cpu_addr  = addr;
        cpu_wdata = data;
        ref_mem[addr] = data;
        while (n < 12 && !done) begin
            @(negedge clk);
            chk("st_wr_en", 32'(mem_wr_en), 32'(n < 4));
            chk("st_rd_en", 32'(mem_rd_en), 32'd0);
            chk("st_rdata", cpu_rdata, 32'd0);
            if (!stall) begin
                chk("st_latency", 32'(n), 32'd4);
                chk("st_mem_addr", 32'(mem_addr), 32'(addr));
                chk("st_mem_wdata", mem_wdata, data);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("st_timeout", 32'(done), 32'd1);
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_stall"},  32'(stall),     32'd0);
        chk({tag, "_rd_en"},  32'(mem_rd_en), 32'd0);
        chk({tag, "_wr_en"},  32'(mem_wr_en), 32'd0);
        chk({tag, "_addr"},   32'(mem_addr),  32'd0);
        chk({tag, "_wdata"},  mem_wdata,      32'd0);
        chk({tag, "_rdata"},  cpu_rdata,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hA000_0000 | 32'(i);
        rst       = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Cold miss fills line, then hit in the same line.
        do_load(10'h010, 4);
        do_load(10'h012, 0);

        // Store hit updates line and memory; load returns it without waiting.
        do_store(10'h011, 32'h0000_0055, 1'b0);
        do_load(10'h011, 0);
        chk("mem_0x011", mem[10'h011], 32'h0000_0055);

        // Store miss does not allocate.
        do_store(10'h200, 32'hDEAD_BEEF, 1'b0);
        do_load(10'h200, 4);

        // Simultaneous load and store: store only.
        do_store(10'h020, 32'h1234_5678, 1'b1);
        do_load(10'h020, 4);

        // Reset in cycle 2 of a read miss aborts it.
        cpu_rd   = 1'b1;
        cpu_addr = 10'h090;
        @(negedge clk);
        chk("abort_c0_stall", 32'(stall),     32'd1);
        chk("abort_c0_rd_en", 32'(mem_rd_en), 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cpu_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("abort");
        @(posedge clk);
        #1;
        do_load(10'h090, 4);

        // Conflict on index 4: tag 0 and tag 1 evict each other.
        do_load(10'h010, 4);
        do_load(10'h090, 4);
        do_load(10'h010, 4);
        do_load(10'h011, 0);

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
